fractal_sync_tx_arb: RTL

Round-robin scheduler that drains the response FIFOs of one or more fractal sync tx datapaths (en/ws FIFOs, combinational-output) onto a single downstream response link with valid/ready handshake. Sits between the tx FIFO outputs and the shared link toward the lower tree level. Generates the FIFO pop strobes and latches per-source overflow errors into sticky status.

---
 rtl/fractal_sync_pkg.sv | 22 ++
 rtl/fractal_sync_tx_arb_if.sv | 22 ++
 rtl/fractal_sync_rr_arb.sv | 63 ++++++
 rtl/fractal_sync_tx_arb.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/fractal_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fractal_sync_pkg
// Purpose  : Shared response type for the fractal sync tree. The same
//            response struct travels on every tx FIFO and on the shared
//            downstream link.
// Contents : DST_W       - width of the destination field
//            fsync_rsp_t - {wake, dst, error}
// Revision : 1.0 - initial release
// ============================================================================
package fractal_sync_pkg;

  localparam int unsigned DST_W = 4;

  typedef struct packed {
    logic             wake;
    logic [DST_W-1:0] dst;
    logic             error;
  } fsync_rsp_t;

endpackage
`default_nettype wire

// File: rtl/fractal_sync_tx_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : fractal_sync_tx_arb_if
// Purpose  : Valid/ready response link toward the lower tree level.
// Signals  : rsp   - response payload (driven by master)
//            valid - payload valid    (driven by master)
//            ready - sink accepts     (driven by slave)
// Modports : master (response producer), slave (response consumer)
// Revision : 1.0 - initial release
// ============================================================================
interface fractal_sync_tx_arb_if;
  import fractal_sync_pkg::*;

  fsync_rsp_t rsp;
  logic       valid;
  logic       ready;

  modport master (output rsp, output valid, input ready);
  modport slave  (input rsp, input valid, output ready);

endinterface
`default_nettype wire

// File: rtl/fractal_sync_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : fractal_sync_rr_arb
// Purpose  : Round-robin arbiter. Grants the first requester found searching
//            upward (with wrap) from the pointer rr_q; on advance the pointer
//            moves to one past the granted index.
// Ports    : clk_i, rst_ni (async, active-low)
//            req_i     [N]     - request vector
//            advance_i         - grant consumed this cycle, move pointer
//            gnt_o     [N]     - one-hot grant (zero when no request)
//            gnt_idx_o [IDX_W] - index of the granted requester
// Revision : 1.0 - initial release
// ============================================================================
module fractal_sync_rr_arb #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     req_i,
  input  logic             advance_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] idx;
  int unsigned      idx_int;
  int unsigned      nxt;
  logic             found;

  // rr_q is always kept below N, so a single subtraction performs the wrap.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx_int   = 0;
    idx       = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx_int = 32'(rr_q) + off;
      if (idx_int >= N) idx_int = idx_int - N;
      idx = IDX_W'(idx_int);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

  always_comb begin
    nxt  = 32'(gnt_idx_o) + 1;
    rr_d = rr_q;
    if (advance_i) rr_d = (nxt >= N) ? '0 : IDX_W'(nxt);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else         rr_q <= rr_d;
  end

endmodule
`default_nettype wire

// File: rtl/fractal_sync_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : fractal_sync_tx_arb
// Purpose  : Round-robin drain of N_SRC tx response FIFOs onto one valid/ready
//            link, with optional output register, sticky overflow status and a
//            delivered-response counter.
// Ports    : clk_i, rst_ni (async, active-low)
//            empty_i          [N_SRC]   - per-source FIFO empty
//            rsp_i            [N_SRC]   - per-source FIFO head
//            pop_o            [N_SRC]   - per-source pop strobe (one-hot/zero)
//            error_overflow_i [N_SRC]   - per-source overflow pulse
//            rsp_link         (master)  - downstream rsp/valid/ready
//            clear_error_i              - clear all sticky errors
//            error_sticky_o   [N_SRC]   - latched overflow per source
//            delivered_cnt_o  [CNT_W]   - completed handshakes (wrapping)
//            busy_o                     - output valid or any FIFO non-empty
// Revision : 1.0 - initial release
// ============================================================================
module fractal_sync_tx_arb
  import fractal_sync_pkg::*;
#(
  parameter int unsigned N_SRC   = 2,
  parameter bit          OUT_REG = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_SRC-1:0]       empty_i,
  input  fsync_rsp_t [N_SRC-1:0] rsp_i,
  output logic [N_SRC-1:0]       pop_o,
  input  logic [N_SRC-1:0]       error_overflow_i,
  fractal_sync_tx_arb_if.master  rsp_link,
  input  logic                   clear_error_i,
  output logic [N_SRC-1:0]       error_sticky_o,
  output logic [CNT_W-1:0]       delivered_cnt_o,
  output logic                   busy_o
);

  localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  logic [N_SRC-1:0] req, gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             any_req, pop_en, valid, hs;
  fsync_rsp_t       head, rsp_out;
  logic [N_SRC-1:0] sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q;

  assign req     = ~empty_i;
  assign any_req = |req;
  assign head    = rsp_i[gnt_idx];

  fractal_sync_rr_arb #(
    .N     (N_SRC),
    .IDX_W (IDX_W)
  ) i_rr_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req),
    .advance_i (pop_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  if (OUT_REG) begin : g_out_reg
    state_e     state_q, state_d;
    fsync_rsp_t rsp_q, rsp_d;
    logic       load;

    // FULL with ready: the slot drains and refills in the same cycle.
    always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
        ST_EMPTY: begin
          if (any_req) begin
            load    = 1'b1;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (rsp_link.ready) begin
            if (any_req) load    = 1'b1;
            else         state_d = ST_EMPTY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
      rsp_d = load ? head : rsp_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= ST_EMPTY;
        rsp_q   <= '0;
      end else begin
        state_q <= state_d;
        rsp_q   <= rsp_d;
      end
    end

    // State sits in EMPTY during reset but would still see requests, so the
    // pop is gated by reset explicitly.
    assign pop_en  = load & rst_ni;
    assign valid   = (state_q == ST_FULL);
    assign rsp_out = rsp_q;
  end else begin : g_pass
    assign valid   = any_req & rst_ni;
    assign rsp_out = rst_ni ? head : '0;
    assign pop_en  = valid & rsp_link.ready;
  end

  assign pop_o          = gnt & {N_SRC{pop_en}};
  assign rsp_link.valid = valid;
  assign rsp_link.rsp   = rsp_out;
  assign hs             = valid & rsp_link.ready;
  assign busy_o         = valid | any_req;

  // A new overflow in the clear cycle must survive, so set is OR-ed last.
  assign sticky_d = (sticky_q & ~{N_SRC{clear_error_i}}) | error_overflow_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_q <= '0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      if (hs) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign error_sticky_o  = sticky_q;
  assign delivered_cnt_o = cnt_q;

endmodule
`default_nettype wire
